// File: rtl/adder_pipe_if.sv
// Handshake bundle for adder_pipe: operand beat on the input side, result beat on the output side.
// The master drives operands and out_ready; the slave (the adder) drives results and in_ready.
interface adder_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, ovf
    );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined add/subtract: each stage resolves one CHUNK-bit slice of the carry chain and registers
// the carry into the next stage; the last stage register is the output register.
module adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    adder_pipe_if.slave bus
);
    localparam int CHUNK = (STAGES >= 1 && WIDTH >= STAGES) ? WIDTH / STAGES : 1;
    localparam int LAST  = (STAGES >= 1) ? STAGES - 1 : 0;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("adder_pipe: STAGES must be in 1..WIDTH and divide WIDTH evenly");
    end

    // Stage registers; index k holds a beat whose slices 0..k are resolved.
    logic             v_q  [STAGES];
    logic             c_q  [STAGES];
    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] bx_q [STAGES];
    logic [WIDTH-1:0] r_q  [STAGES];
    logic             ovf_q;

    logic             v_i  [STAGES];
    logic             c_i  [STAGES];
    logic [WIDTH-1:0] a_i  [STAGES];
    logic [WIDTH-1:0] bx_i [STAGES];
    logic [WIDTH-1:0] r_i  [STAGES];

    logic             c_n  [STAGES];
    logic [WIDTH-1:0] r_n  [STAGES];
    logic             ovf_n;
    logic [CHUNK:0]   part;
    logic             stall;

    always_comb begin
        v_i[0]  = bus.in_valid;
        a_i[0]  = bus.a;
        bx_i[0] = bus.sub ? ~bus.b : bus.b;
        c_i[0]  = bus.sub | bus.cin;
        r_i[0]  = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_i[k]  = v_q[k-1];
            a_i[k]  = a_q[k-1];
            bx_i[k] = bx_q[k-1];
            c_i[k]  = c_q[k-1];
            r_i[k]  = r_q[k-1];
        end
    end

    always_comb begin
        part = '0;
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, a_i[k][k*CHUNK +: CHUNK]}
                 + {1'b0, bx_i[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_i[k]};
            r_n[k] = r_i[k];
            r_n[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
            c_n[k] = part[CHUNK];
        end
        // Overflow only makes sense once the MSB slice is resolved, i.e. entering the last register.
        ovf_n = (a_i[LAST][WIDTH-1] == bx_i[LAST][WIDTH-1])
             && (r_n[LAST][WIDTH-1] != a_i[LAST][WIDTH-1]);
    end

    assign stall = v_q[LAST] && !bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= 1'b0;
                c_q[k]  <= 1'b0;
                a_q[k]  <= '0;
                bx_q[k] <= '0;
                r_q[k]  <= '0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= v_i[k];
                c_q[k]  <= c_n[k];
                a_q[k]  <= a_i[k];
                bx_q[k] <= bx_i[k];
                r_q[k]  <= r_n[k];
            end
            ovf_q <= ovf_n;
        end
    end

    assign bus.in_ready  = !stall;
    assign bus.out_valid = v_q[LAST];
    assign bus.sum       = {c_q[LAST], r_q[LAST]};
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed vectors, bubbles, backpressure and mid-stream reset on an 8/2 pipe,
// plus exhaustive 4-bit runs on STAGES=4 and STAGES=1 pipes against an arithmetic reference.
module tb_adder_pipe;
    localparam int STG8 = 2;
    localparam int NEXH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    adder_pipe_if #(.WIDTH(8)) b8 ();
    adder_pipe_if #(.WIDTH(4)) x4 ();
    adder_pipe_if #(.WIDTH(4)) x1 ();

    adder_pipe #(.WIDTH(8), .STAGES(STG8)) dut    (.clk(clk), .rst_n(rst_n), .bus(b8));
    adder_pipe #(.WIDTH(4), .STAGES(4))    dut_s4 (.clk(clk), .rst_n(rst_n), .bus(x4));
    adder_pipe #(.WIDTH(4), .STAGES(1))    dut_s1 (.clk(clk), .rst_n(rst_n), .bus(x1));

    // Index 0 drives the STAGES=4 pipe, index 1 the STAGES=1 pipe.
    logic       e_vld [2];
    logic       e_sub [2];
    logic       e_cin [2];
    logic       e_rdy [2];
    logic [3:0] e_a   [2];
    logic [3:0] e_b   [2];
    logic       e_ov  [2];
    logic       e_ir  [2];
    logic       e_ovf [2];
    logic [4:0] e_sum [2];

    assign x4.in_valid = e_vld[0];
    assign x4.a        = e_a[0];
    assign x4.b        = e_b[0];
    assign x4.sub      = e_sub[0];
    assign x4.cin      = e_cin[0];
    assign x4.out_ready = e_rdy[0];
    assign e_ov[0]  = x4.out_valid;
    assign e_ir[0]  = x4.in_ready;
    assign e_sum[0] = x4.sum;
    assign e_ovf[0] = x4.ovf;

    assign x1.in_valid = e_vld[1];
    assign x1.a        = e_a[1];
    assign x1.b        = e_b[1];
    assign x1.sub      = e_sub[1];
    assign x1.cin      = e_cin[1];
    assign x1.out_ready = e_rdy[1];
    assign e_ov[1]  = x1.out_valid;
    assign e_ir[1]  = x1.in_ready;
    assign e_sum[1] = x1.sum;
    assign e_ovf[1] = x1.ovf;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [8:0] sum;
        logic       ovf;
    } vec_t;

    vec_t tv [6];
    bit   pat  [8];
    bit   seen [8];

    // {carry,result} as plain modular arithmetic: subtraction is a - b + 2^w.
    function automatic int ref_sum(int w, int a, int b, bit s, bit ci);
        int r;
        if (s) r = a - b + (1 << w);
        else   r = a + b + int'(ci);
        return r % (1 << (w + 1));
    endfunction

    // Overflow means the true signed result does not fit in w bits.
    function automatic int ref_ovf(int w, int a, int b, bit s, bit ci);
        int half, sa, sb, r;
        half = 1 << (w - 1);
        sa = (a >= half) ? a - 2 * half : a;
        sb = (b >= half) ? b - 2 * half : b;
        r  = s ? sa - sb : sa + sb + int'(ci);
        return ((r < -half) || (r >= half)) ? 1 : 0;
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic run_vec(int i);
        int lat;
        @(negedge clk);
        b8.out_ready = 1'b1;
        b8.in_valid  = 1'b1;
        b8.a   = tv[i].a;
        b8.b   = tv[i].b;
        b8.sub = tv[i].sub;
        b8.cin = tv[i].cin;
        @(negedge clk);
        b8.in_valid = 1'b0;
        lat = 0;
        while (!b8.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("vec%0d_latency", i), lat, STG8 - 1);
        check($sformatf("vec%0d_sum", i), int'(b8.sum), int'(tv[i].sum));
        check($sformatf("vec%0d_ovf", i), int'(b8.ovf), int'(tv[i].ovf));
    endtask

    task automatic stream(int nbeats, bit rnd);
        logic [9:0] exp_q[$];
        int sent, recv, cyc, rs, ro;
        bit taken;
        sent = 0; recv = 0; cyc = 0; taken = 1'b1;
        while (recv < nbeats && cyc < 3000) begin
            @(negedge clk);
            if (taken || !b8.in_valid) begin
                if (sent < nbeats && (!rnd || $urandom_range(3) != 0)) begin
                    b8.in_valid = 1'b1;
                    b8.a   = 8'($urandom);
                    b8.b   = 8'($urandom);
                    b8.sub = 1'($urandom);
                    b8.cin = 1'($urandom);
                end else begin
                    b8.in_valid = 1'b0;
                end
            end
            if (rnd) b8.out_ready = ($urandom_range(3) != 0);
            else     b8.out_ready = !(cyc >= 4 && cyc <= 8);
            #1;
            check("in_ready_rule", int'(b8.in_ready), int'(!(b8.out_valid && !b8.out_ready)));
            if (b8.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream_spurious_valid", 1, 0);
                end else begin
                    check("stream_sum", int'(b8.sum), int'(exp_q[0][8:0]));
                    check("stream_ovf", int'(b8.ovf), int'(exp_q[0][9]));
                    if (b8.out_ready) begin
                        void'(exp_q.pop_front());
                        recv++;
                    end
                end
            end
            taken = b8.in_valid && b8.in_ready;
            if (taken) begin
                rs = ref_sum(8, int'(b8.a), int'(b8.b), b8.sub, b8.cin);
                ro = ref_ovf(8, int'(b8.a), int'(b8.b), b8.sub, b8.cin);
                exp_q.push_back({ro[0], rs[8:0]});
                sent++;
            end
            cyc++;
        end
        check("stream_delivered", recv, nbeats);
        check("stream_sent", sent, nbeats);
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stream_no_extra", int'(b8.out_valid), 0);
        end
    endtask

    initial begin
        int cyc, rs, ro;
        int e_sent [2];
        int e_recv [2];
        logic [9:0] v;

        tv[0] = '{8'hF0, 8'h20, 1'b0, 1'b0, 9'h110, 1'b0};
        tv[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 9'h080, 1'b1};
        tv[2] = '{8'hFF, 8'h00, 1'b0, 1'b1, 9'h100, 1'b0};
        tv[3] = '{8'h05, 8'h07, 1'b1, 1'b0, 9'h0FE, 1'b0};
        tv[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 9'h17F, 1'b1};
        tv[5] = '{8'h10, 8'h10, 1'b1, 1'b1, 9'h100, 1'b0};
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.sub = 1'b0; b8.cin = 1'b0; b8.out_ready = 1'b1;
        for (int d = 0; d < 2; d++) begin
            e_vld[d] = 1'b0; e_a[d] = '0; e_b[d] = '0; e_sub[d] = 1'b0; e_cin[d] = 1'b0; e_rdy[d] = 1'b1;
            e_sent[d] = 0; e_recv[d] = 0;
        end

        #1;
        check("reset_out_valid", int'(b8.out_valid), 0);
        check("reset_sum", int'(b8.sum), 0);
        check("reset_ovf", int'(b8.ovf), 0);
        check("reset_in_ready", int'(b8.in_ready), 1);
        check("reset_s4_valid", int'(e_ov[0]), 0);
        check("reset_s1_valid", int'(e_ov[1]), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i);

        b8.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen[i] = b8.out_valid;
            b8.in_valid = pat[i];
            b8.a = 8'(i);
            b8.b = 8'(3 * i);
        end
        b8.in_valid = 1'b0;
        for (int i = 0; i < 8; i++)
            check($sformatf("bubble_out_valid_%0d", i), int'(seen[i]), (i >= STG8) ? int'(pat[i-STG8]) : 0);

        stream(10, 1'b0);
        stream(200, 1'b1);

        // Two beats in flight, held by backpressure, then an asynchronous reset between edges.
        @(negedge clk);
        b8.out_ready = 1'b0;
        b8.in_valid = 1'b1; b8.a = 8'h7F; b8.b = 8'h01; b8.sub = 1'b0; b8.cin = 1'b0;
        @(negedge clk);
        b8.a = 8'h3C; b8.b = 8'h4B; b8.cin = 1'b1;
        @(negedge clk);
        b8.in_valid = 1'b0;
        check("pre_reset_valid", int'(b8.out_valid), 1);
        check("pre_reset_sum", int'(b8.sum), 9'h080);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", int'(b8.out_valid), 0);
        check("async_reset_sum", int'(b8.sum), 0);
        check("async_reset_ovf", int'(b8.ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        b8.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_reset_no_stale", int'(b8.out_valid), 0);
        end

        cyc = 0;
        while ((e_recv[0] < NEXH || e_recv[1] < NEXH) && cyc < 8000) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                v = 10'(e_sent[d]);
                e_vld[d] = (e_sent[d] < NEXH);
                e_a[d]   = v[3:0];
                e_b[d]   = v[7:4];
                e_sub[d] = v[8];
                e_cin[d] = v[9];
                e_rdy[d] = ($urandom_range(3) != 0);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                if (e_ov[d] && e_rdy[d]) begin
                    v  = 10'(e_recv[d]);
                    rs = ref_sum(4, int'(v[3:0]), int'(v[7:4]), v[8], v[9]);
                    ro = ref_ovf(4, int'(v[3:0]), int'(v[7:4]), v[8], v[9]);
                    check((d == 0) ? "exh_s4_sum" : "exh_s1_sum", int'(e_sum[d]), rs);
                    check((d == 0) ? "exh_s4_ovf" : "exh_s1_ovf", int'(e_ovf[d]), ro);
                    e_recv[d]++;
                end
                if (e_vld[d] && e_ir[d]) e_sent[d]++;
            end
            cyc++;
        end
        check("exh_s4_count", e_recv[0], NEXH);
        check("exh_s1_count", e_recv[1], NEXH);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
